// File: rtl/decode_issue_stage.sv
// decode_issue_stage
//   Instruction-decode stage of the 32-bit pipeline. Decodes the fetched
//   word, drives the register-file read addresses, resolves both source
//   operands (EX forward > WB forward > register file), detects load-use
//   hazards and captures the result into the ID/EX pipeline register.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   if_valid/if_instr/if_pc   fetch word, its valid and PC
//   id_ready              stage accepts the fetch word this cycle
//   rf_rd_addr_1/2        register-file read addresses (rs / rt)
//   rf_rd_data_1/2        register-file read data
//   ex_fwd_*, wb_fwd_*    forwarding sources from EX and WB
//   ex_stall              execute cannot accept; ID/EX holds
//   flush                 redirect; kill the fetch word and the ID/EX entry
//   dx_*                  ID/EX pipeline register contents
//   stall_count           saturating count of load-use stall cycles
module decode_issue_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc,
  output logic                   id_ready,
  output logic [4:0]             rf_rd_addr_1,
  output logic [4:0]             rf_rd_addr_2,
  input  logic [31:0]            rf_rd_data_1,
  input  logic [31:0]            rf_rd_data_2,
  input  logic                   ex_fwd_en,
  input  logic [4:0]             ex_fwd_reg,
  input  logic [31:0]            ex_fwd_data,
  input  logic                   wb_fwd_en,
  input  logic [4:0]             wb_fwd_reg,
  input  logic [31:0]            wb_fwd_data,
  input  logic                   ex_stall,
  input  logic                   flush,
  output logic                   dx_valid,
  output logic [31:0]            dx_pc,
  output logic [5:0]             dx_opcode,
  output logic [5:0]             dx_funct,
  output logic [31:0]            dx_op_a,
  output logic [31:0]            dx_op_b,
  output logic [31:0]            dx_imm,
  output logic [4:0]             dx_dest,
  output logic                   dx_reg_write,
  output logic                   dx_mem_read,
  output logic                   dx_mem_write,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_e;

  state_e state_q, state_d;

  logic                   dx_valid_q, dx_valid_d;
  logic [31:0]            dx_pc_q, dx_pc_d;
  logic [5:0]             dx_opcode_q, dx_opcode_d;
  logic [5:0]             dx_funct_q, dx_funct_d;
  logic [31:0]            dx_op_a_q, dx_op_a_d;
  logic [31:0]            dx_op_b_q, dx_op_b_d;
  logic [31:0]            dx_imm_q, dx_imm_d;
  logic [4:0]             dx_dest_q, dx_dest_d;
  logic                   dx_mem_read_q, dx_mem_read_d;
  logic                   dx_mem_write_q, dx_mem_write_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]  opcode_s;
  logic [4:0]  rs_s, rt_s, dest_s;
  logic [31:0] imm_s, op_a_s, op_b_s;
  logic        use_rs_s, use_rt_s, hazard_s, take_hazard_s;

  // Priority EX > WB > register file; r0 always reads as zero.
  function automatic logic [31:0] resolve_operand(
    input logic [4:0]  src,
    input logic [31:0] rf_data,
    input logic        ex_en,
    input logic [4:0]  ex_reg,
    input logic [31:0] ex_data,
    input logic        wb_en,
    input logic [4:0]  wb_reg,
    input logic [31:0] wb_data
  );
    logic [31:0] r;
    if (src == 5'd0) begin
      r = 32'd0;
    end else if (ex_en && (ex_reg == src)) begin
      r = ex_data;
    end else if (wb_en && (wb_reg == src)) begin
      r = wb_data;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction

  assign rf_rd_addr_1 = if_instr[25:21];
  assign rf_rd_addr_2 = if_instr[20:16];

  // Field decode, source usage, immediate and operand resolution.
  always_comb begin
    opcode_s = if_instr[31:26];
    rs_s     = if_instr[25:21];
    rt_s     = if_instr[20:16];
    dest_s   = rt_s;
    use_rs_s = 1'b1;
    use_rt_s = 1'b0;
    imm_s    = {{16{if_instr[15]}}, if_instr[15:0]};
    case (opcode_s)
      OP_RTYPE: begin
        dest_s   = if_instr[15:11];
        use_rt_s = 1'b1;
      end
      OP_JAL: begin
        dest_s   = 5'd31;
        use_rs_s = 1'b0;
      end
      OP_J: begin
        dest_s   = 5'd0;
        use_rs_s = 1'b0;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        dest_s   = 5'd0;
        use_rt_s = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: imm_s = {16'd0, if_instr[15:0]};
      default: dest_s = rt_s;
    endcase
    op_a_s = resolve_operand(rs_s, rf_rd_data_1, ex_fwd_en, ex_fwd_reg, ex_fwd_data,
                             wb_fwd_en, wb_fwd_reg, wb_fwd_data);
    op_b_s = resolve_operand(rt_s, rf_rd_data_2, ex_fwd_en, ex_fwd_reg, ex_fwd_data,
                             wb_fwd_en, wb_fwd_reg, wb_fwd_data);
  end

  // A load in ID/EX whose destination feeds a used source of the fetch word.
  // The state check is redundant with the cleared dx_mem_read but keeps the
  // bubble cycle hazard-free by construction.
  assign hazard_s = (state_q == ST_RUN) && dx_valid_q && dx_mem_read_q &&
                    (dx_dest_q != 5'd0) && if_valid &&
                    ((use_rs_s && (dx_dest_q == rs_s)) ||
                     (use_rt_s && (dx_dest_q == rt_s)));

  // FSM next state and handshake; flush outranks stall, stall outranks hazard.
  always_comb begin
    state_d       = ST_RUN;
    take_hazard_s = 1'b0;
    id_ready      = 1'b1;
    if (flush) begin
      id_ready = 1'b1;
    end else if (ex_stall) begin
      id_ready = 1'b0;
    end else if (hazard_s) begin
      id_ready      = 1'b0;
      take_hazard_s = 1'b1;
    end else begin
      id_ready = 1'b1;
    end
    case (state_q)
      ST_RUN:    state_d = take_hazard_s ? ST_BUBBLE : ST_RUN;
      ST_BUBBLE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // ID/EX register next-state.
  always_comb begin
    dx_valid_d     = dx_valid_q;
    dx_pc_d        = dx_pc_q;
    dx_opcode_d    = dx_opcode_q;
    dx_funct_d     = dx_funct_q;
    dx_op_a_d      = dx_op_a_q;
    dx_op_b_d      = dx_op_b_q;
    dx_imm_d       = dx_imm_q;
    dx_dest_d      = dx_dest_q;
    dx_mem_read_d  = dx_mem_read_q;
    dx_mem_write_d = dx_mem_write_q;
    stall_cnt_d    = stall_cnt_q;
    if (flush) begin
      dx_valid_d = 1'b0;
    end else if (ex_stall) begin
      dx_valid_d = dx_valid_q;
    end else if (take_hazard_s) begin
      dx_valid_d    = 1'b0;
      dx_mem_read_d = 1'b0;
      if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      dx_valid_d     = if_valid;
      dx_pc_d        = if_pc;
      dx_opcode_d    = opcode_s;
      dx_funct_d     = if_instr[5:0];
      dx_op_a_d      = op_a_s;
      dx_op_b_d      = op_b_s;
      dx_imm_d       = imm_s;
      dx_dest_d      = dest_s;
      dx_mem_read_d  = (opcode_s == OP_LW);
      dx_mem_write_d = (opcode_s == OP_SW);
    end
  end

  // State and ID/EX registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      dx_valid_q     <= 1'b0;
      dx_pc_q        <= 32'd0;
      dx_opcode_q    <= 6'd0;
      dx_funct_q     <= 6'd0;
      dx_op_a_q      <= 32'd0;
      dx_op_b_q      <= 32'd0;
      dx_imm_q       <= 32'd0;
      dx_dest_q      <= 5'd0;
      dx_mem_read_q  <= 1'b0;
      dx_mem_write_q <= 1'b0;
      stall_cnt_q    <= {STALL_CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      dx_valid_q     <= dx_valid_d;
      dx_pc_q        <= dx_pc_d;
      dx_opcode_q    <= dx_opcode_d;
      dx_funct_q     <= dx_funct_d;
      dx_op_a_q      <= dx_op_a_d;
      dx_op_b_q      <= dx_op_b_d;
      dx_imm_q       <= dx_imm_d;
      dx_dest_q      <= dx_dest_d;
      dx_mem_read_q  <= dx_mem_read_d;
      dx_mem_write_q <= dx_mem_write_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign dx_valid     = dx_valid_q;
  assign dx_pc        = dx_pc_q;
  assign dx_opcode    = dx_opcode_q;
  assign dx_funct     = dx_funct_q;
  assign dx_op_a      = dx_op_a_q;
  assign dx_op_b      = dx_op_b_q;
  assign dx_imm       = dx_imm_q;
  assign dx_dest      = dx_dest_q;
  assign dx_reg_write = (dx_dest_q != 5'd0);
  assign dx_mem_read  = dx_mem_read_q;
  assign dx_mem_write = dx_mem_write_q;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed instruction vectors push
// hand-computed ID/EX contents into a queue; a negedge monitor pops and
// compares whenever dx_valid is presented.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic [31:0] if_pc = 32'd0;
  logic        id_ready;
  logic [4:0]  rf_rd_addr_1, rf_rd_addr_2;
  logic [31:0] rf_rd_data_1, rf_rd_data_2;
  logic        ex_fwd_en = 1'b0;
  logic [4:0]  ex_fwd_reg = 5'd0;
  logic [31:0] ex_fwd_data = 32'd0;
  logic        wb_fwd_en = 1'b0;
  logic [4:0]  wb_fwd_reg = 5'd0;
  logic [31:0] wb_fwd_data = 32'd0;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;
  logic        dx_valid;
  logic [31:0] dx_pc, dx_op_a, dx_op_b, dx_imm;
  logic [5:0]  dx_opcode, dx_funct;
  logic [4:0]  dx_dest;
  logic        dx_reg_write, dx_mem_read, dx_mem_write;
  logic [15:0] stall_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [2:0]  flags;  // {reg_write, mem_read, mem_write}
  } rec_t;

  rec_t exp_q[$];
  rec_t last_rec = '0;
  logic held = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  decode_issue_stage #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_rd_addr_1(rf_rd_addr_1), .rf_rd_addr_2(rf_rd_addr_2),
    .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_reg(ex_fwd_reg), .ex_fwd_data(ex_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg), .wb_fwd_data(wb_fwd_data),
    .ex_stall(ex_stall), .flush(flush), .dx_valid(dx_valid), .dx_pc(dx_pc),
    .dx_opcode(dx_opcode), .dx_funct(dx_funct), .dx_op_a(dx_op_a), .dx_op_b(dx_op_b),
    .dx_imm(dx_imm), .dx_dest(dx_dest), .dx_reg_write(dx_reg_write),
    .dx_mem_read(dx_mem_read), .dx_mem_write(dx_mem_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Register-file model: register i holds 0x11*i.
  assign rf_rd_data_1 = 32'h11 * {27'd0, rf_rd_addr_1};
  assign rf_rd_data_2 = 32'h11 * {27'd0, rf_rd_addr_2};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_rec(input string nm, input rec_t act, input rec_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s pc=%h: got pc=%h opc=%h fn=%h a=%h b=%h imm=%h dst=%0d fl=%b expected pc=%h opc=%h fn=%h a=%h b=%h imm=%h dst=%0d fl=%b",
                  nm, exp.pc, act.pc, act.opcode, act.funct, act.op_a, act.op_b, act.imm, act.dest, act.flags,
                  exp.pc, exp.opcode, exp.funct, exp.op_a, exp.op_b, exp.imm, exp.dest, exp.flags);
  endtask

  function automatic rec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [4:0] dest,
                              input logic [2:0] flags);
    rec_t r;
    r.pc = pc; r.opcode = instr[31:26]; r.funct = instr[5:0];
    r.op_a = a; r.op_b = b; r.imm = imm; r.dest = dest; r.flags = flags;
    return r;
  endfunction

  // Track whether the last edge held ID/EX (stall without flush).
  always @(posedge clk) held <= ex_stall && !flush;

  // Monitor: compare each presented ID/EX entry against the scoreboard.
  always @(negedge clk) begin
    rec_t act;
    if (!rst && dx_valid) begin
      act = '{dx_pc, dx_opcode, dx_funct, dx_op_a, dx_op_b, dx_imm, dx_dest,
              {dx_reg_write, dx_mem_read, dx_mem_write}};
      if (held) begin
        chk_rec("hold", act, last_rec);
      end else if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_issue: got dx_valid=1 pc=%h expected no entry", dx_pc);
      end else begin
        last_rec = exp_q.pop_front();
        chk_rec("issue", act, last_rec);
      end
    end
  end

  task automatic at_neg(input logic [31:0] instr, input logic [31:0] pc, input logic v);
    @(negedge clk);
    if_instr = instr; if_pc = pc; if_valid = v;
    ex_fwd_en = 1'b0; ex_fwd_reg = 5'd0; ex_fwd_data = 32'd0;
    wb_fwd_en = 1'b0; wb_fwd_reg = 5'd0; wb_fwd_data = 32'd0;
    ex_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic exf(input logic en, input logic [4:0] r, input logic [31:0] d);
    ex_fwd_en = en; ex_fwd_reg = r; ex_fwd_data = d;
  endtask

  task automatic wbf(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_fwd_en = en; wb_fwd_reg = r; wb_fwd_data = d;
  endtask

  task automatic rdy(input logic exp, input string nm);
    #1 chk(nm, {63'd0, id_ready}, {63'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_dx_valid", {63'd0, dx_valid}, 64'd0);
    chk("rst_stall_count", {48'd0, stall_count}, 64'd0);
    chk("rst_ready", {63'd0, id_ready}, 64'd1);
    chk("rst_fields", {dx_pc, dx_op_a}, 64'd0);

    // add r3,r1,r2: EX beats WB for rs, rt from register file
    at_neg(32'h00221820, 32'h100, 1'b1); exf(1'b1, 5'd1, 32'hAA); wbf(1'b1, 5'd1, 32'hBB);
    rdy(1'b1, "ready_add");
    chk("rf_addr", {54'd0, rf_rd_addr_1, rf_rd_addr_2}, {54'd0, 5'd1, 5'd2});
    exp_q.push_back(mk(32'h00221820, 32'h100, 32'hAA, 32'h22, 32'h1820, 5'd3, 3'b100));

    // add r4,r0,r0 with forwards aimed at r0
    at_neg(32'h00002020, 32'h104, 1'b1); exf(1'b1, 5'd0, 32'hFFFF); wbf(1'b1, 5'd0, 32'hFFFF);
    rdy(1'b1, "ready_r0");
    exp_q.push_back(mk(32'h00002020, 32'h104, 32'h0, 32'h0, 32'h2020, 5'd4, 3'b100));

    // add r7,r1,r2: disabled EX forward ignored, WB forward on rt
    at_neg(32'h00223820, 32'h108, 1'b1); exf(1'b0, 5'd1, 32'hDEAD); wbf(1'b1, 5'd2, 32'h55);
    rdy(1'b1, "ready_wb");
    exp_q.push_back(mk(32'h00223820, 32'h108, 32'h11, 32'h55, 32'h3820, 5'd7, 3'b100));

    // lw r5,4(r1) then add r6,r5,r2 -> one bubble
    at_neg(32'h8C250004, 32'h10C, 1'b1); rdy(1'b1, "ready_lw");
    exp_q.push_back(mk(32'h8C250004, 32'h10C, 32'h11, 32'h55, 32'h4, 5'd5, 3'b110));
    at_neg(32'h00A23020, 32'h110, 1'b1); rdy(1'b0, "ready_loaduse");
    at_neg(32'h00A23020, 32'h110, 1'b1); exf(1'b1, 5'd5, 32'h1234);
    rdy(1'b1, "ready_after_bubble");
    chk("bubble_valid", {63'd0, dx_valid}, 64'd0);
    chk("stall_count_1", {48'd0, stall_count}, 64'd1);
    exp_q.push_back(mk(32'h00A23020, 32'h110, 32'h1234, 32'h22, 32'h3020, 5'd6, 3'b100));

    // Immediates and jal
    at_neg(32'h34088001, 32'h114, 1'b1); rdy(1'b1, "ready_ori");
    exp_q.push_back(mk(32'h34088001, 32'h114, 32'h0, 32'h88, 32'h00008001, 5'd8, 3'b100));
    at_neg(32'h20098001, 32'h118, 1'b1); rdy(1'b1, "ready_addi");
    exp_q.push_back(mk(32'h20098001, 32'h118, 32'h0, 32'h99, 32'hFFFF8001, 5'd9, 3'b100));
    at_neg(32'h0C000010, 32'h11C, 1'b1); rdy(1'b1, "ready_jal");
    exp_q.push_back(mk(32'h0C000010, 32'h11C, 32'h0, 32'h0, 32'h10, 5'd31, 3'b100));

    // lw r5 then ori r5,r1,1: rt matches but is not a source -> no hazard
    at_neg(32'h8C250004, 32'h120, 1'b1); rdy(1'b1, "ready_lw2");
    exp_q.push_back(mk(32'h8C250004, 32'h120, 32'h11, 32'h55, 32'h4, 5'd5, 3'b110));
    at_neg(32'h34250001, 32'h124, 1'b1); rdy(1'b1, "ready_rt_unused");
    exp_q.push_back(mk(32'h34250001, 32'h124, 32'h11, 32'h55, 32'h1, 5'd5, 3'b100));

    // lw r5 then sw r5,0(r1): hazard through rt
    at_neg(32'h8C250004, 32'h128, 1'b1); rdy(1'b1, "ready_lw3");
    exp_q.push_back(mk(32'h8C250004, 32'h128, 32'h11, 32'h55, 32'h4, 5'd5, 3'b110));
    at_neg(32'hAC250000, 32'h12C, 1'b1); rdy(1'b0, "ready_sw_hazard");
    at_neg(32'hAC250000, 32'h12C, 1'b1); exf(1'b1, 5'd5, 32'h77);
    rdy(1'b1, "ready_sw_retry");
    chk("stall_count_2", {48'd0, stall_count}, 64'd2);
    exp_q.push_back(mk(32'hAC250000, 32'h12C, 32'h11, 32'h77, 32'h0, 5'd0, 3'b001));

    // ex_stall holds, then flush together with stall kills
    at_neg(32'h20098001, 32'h130, 1'b1); ex_stall = 1'b1; rdy(1'b0, "ready_stall");
    at_neg(32'h20098001, 32'h130, 1'b1); ex_stall = 1'b1; flush = 1'b1;
    rdy(1'b1, "ready_flush");
    at_neg(32'h0, 32'h0, 1'b0); rdy(1'b1, "ready_idle");
    chk("flush_kills", {63'd0, dx_valid}, 64'd0);

    // Reset in the middle of a load-use bubble
    at_neg(32'h8C250004, 32'h200, 1'b1); rdy(1'b1, "ready_lw4");
    exp_q.push_back(mk(32'h8C250004, 32'h200, 32'h11, 32'h55, 32'h4, 5'd5, 3'b110));
    at_neg(32'h00A23020, 32'h204, 1'b1); rdy(1'b0, "ready_loaduse2");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, dx_valid}, 64'd0);
    chk("midrst_stall_count", {48'd0, stall_count}, 64'd0);
    chk("midrst_fields", {dx_pc, 26'd0, dx_dest, dx_mem_read}, 64'd0);
    at_neg(32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    rdy(1'b1, "ready_after_rst");

    // Normal issue after reset
    at_neg(32'h20098001, 32'h300, 1'b1); rdy(1'b1, "ready_post_rst");
    exp_q.push_back(mk(32'h20098001, 32'h300, 32'h0, 32'h99, 32'hFFFF8001, 5'd9, 3'b100));
    at_neg(32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
